// File: rtl/tdm_pkg.sv
// Shared constants, FSM state type and channel offset helper for the
// 8-channel TDM receive path.
package tdm_pkg;
  localparam int NCH  = 8;
  localparam int SELW = 3;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int chan_lsb(input int ch, input int width);
    return ch * width;
  endfunction
endpackage

// File: rtl/tdm_demux8_rx_if.sv
// Stream input and frame output bundle of the TDM demultiplexer.
interface tdm_demux8_rx_if
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
);
  logic                  in_valid;
  logic [WIDTH-1:0]      in_data;
  logic                  frame_start;
  logic [NCH*WIDTH-1:0]  out_data;
  logic                  frame_valid;
  logic [SELW-1:0]       slot;
  logic                  locked;
  logic                  sync_err;

  modport master (
    output in_valid, in_data, frame_start,
    input  out_data, frame_valid, slot, locked, sync_err
  );

  modport slave (
    input  in_valid, in_data, frame_start,
    output out_data, frame_valid, slot, locked, sync_err
  );
endinterface

// File: rtl/demux1to8_dec.sv
// 3-to-8 one-hot decoder with enable; drives the per-channel shadow write enables.
module demux1to8_dec
  import tdm_pkg::*;
(
  input  logic            en,
  input  logic [SELW-1:0] sel,
  output logic [NCH-1:0]  onehot
);

  // One-hot decode of sel, all-zero when disabled or out of range
  always_comb begin
    onehot = 8'h00;
    if (en) begin
      case (sel)
        3'd0:    onehot = 8'h01;
        3'd1:    onehot = 8'h02;
        3'd2:    onehot = 8'h04;
        3'd3:    onehot = 8'h08;
        3'd4:    onehot = 8'h10;
        3'd5:    onehot = 8'h20;
        3'd6:    onehot = 8'h40;
        3'd7:    onehot = 8'h80;
        default: onehot = 8'h00;
      endcase
    end else begin
      onehot = 8'h00;
    end
  end

endmodule

// File: rtl/tdm_demux8_rx.sv
// TDM receive demultiplexer: aligns on frame_start, collects 8 slots in a
// shadow register and publishes each complete frame atomically.
module tdm_demux8_rx
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
)(
  input  logic            clk,
  input  logic            rst,
  tdm_demux8_rx_if.slave  bus
);

  localparam int FW = NCH * WIDTH;

  state_e            state_q, state_d;
  logic [SELW-1:0]   slot_q, slot_d;
  logic [FW-1:0]     shadow_q, shadow_d;
  logic [FW-1:0]     out_data_q, out_data_d;
  logic              frame_valid_q, frame_valid_d;
  logic              sync_err_q, sync_err_d;
  logic              wr_en_s;
  logic [SELW-1:0]   wr_sel_s;
  logic [NCH-1:0]    wr_onehot_s;

  // Shadow write target: a marker always restarts at slot 0
  always_comb begin
    wr_sel_s = bus.frame_start ? {SELW{1'b0}} : slot_q;
    wr_en_s  = 1'b0;
    if (bus.in_valid) begin
      if (state_q == RUN) begin
        wr_en_s = bus.frame_start | (slot_q != {SELW{1'b0}});
      end else begin
        wr_en_s = bus.frame_start;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  demux1to8_dec u_dec (
    .en     (wr_en_s),
    .sel    (wr_sel_s),
    .onehot (wr_onehot_s)
  );

  // Per-channel shadow update from the decoded enables
  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < NCH; k++) begin
      if (wr_onehot_s[k]) begin
        shadow_d[chan_lsb(k, WIDTH) +: WIDTH] = bus.in_data;
      end else begin
        shadow_d[chan_lsb(k, WIDTH) +: WIDTH] = shadow_q[chan_lsb(k, WIDTH) +: WIDTH];
      end
    end
  end

  // Alignment FSM, slot counter and frame publication
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    out_data_d    = out_data_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.frame_start) begin
            slot_d  = 3'd1;
            state_d = RUN;
          end else begin
            state_d = HUNT;
          end
        end
        RUN: begin
          if (bus.frame_start) begin
            // An early marker discards the partial frame and realigns
            sync_err_d = (slot_q != 3'd0);
            slot_d     = 3'd1;
          end else if (slot_q == 3'd0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else begin
            slot_d = slot_q + 3'd1;
            if (slot_q == 3'd7) begin
              out_data_d    = {bus.in_data, shadow_q[FW-WIDTH-1:0]};
              frame_valid_d = 1'b1;
            end else begin
              frame_valid_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          slot_d  = 3'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      slot_q        <= 3'd0;
      shadow_q      <= '0;
      out_data_q    <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      out_data_q    <= out_data_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign bus.out_data    = out_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.slot        = slot_q;
  assign bus.locked      = (state_q == RUN);
  assign bus.sync_err    = sync_err_q;

endmodule

// File: doc/tdm_demux8_rx.md
Name: tdm_demux8_rx

Overview:
- Receive end of the 8:1 channel-multiplexing path: accepts a time-division-multiplexed sample stream, one slot per valid beat, and distributes slots 0..7 into eight channel registers.
- Frame alignment comes from a frame_start marker on slot 0.
- A complete, aligned frame is presented atomically with a one-cycle frame_valid pulse.
- Sits downstream of the mux-based serializer, wherever a channelised stream must be fanned back out.

Parameters:
- WIDTH, 1, bits per channel sample.
- NCH, 8, number of channels (fixed at 8; parameter for readability only).
- SELW, 3, slot index width, log2(NCH).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  in_data holds a slot sample this cycle.
- in_data  input  WIDTH  slot sample.
- frame_start  input  1  qualified by in_valid; current beat is slot 0.
- out_data  output  NCH*WIDTH  last complete frame; channel k at bits [k*WIDTH +: WIDTH].
- frame_valid  output  1  one-cycle pulse: out_data updated this cycle.
- slot  output  SELW  index the next valid beat will be written to.
- locked  output  1  FSM in RUN.
- sync_err  output  1  one-cycle pulse on an alignment violation.

Behaviour:
- Reset (async assert, sync release): out_data=0, frame_valid=0, sync_err=0, slot=0, locked=0, shadow register=0, state=HUNT.
- Beats without in_valid change nothing except clearing the frame_valid/sync_err pulses. frame_start without in_valid is ignored.
- HUNT state:
  - in_valid & !frame_start: beat dropped, no error.
  - in_valid & frame_start: shadow[0]<=in_data, slot<=1, go to RUN.
- RUN state, on in_valid:
  - slot!=0 & !frame_start: shadow[slot]<=in_data, slot<=slot+1 (wraps 7->0).
  - slot==7: shadow[7] written, out_data<={in_data, shadow[6:0]}, frame_valid=1 on the next cycle. Latency is one clock from the slot-7 beat to the out_data/frame_valid edge.
  - slot==0 & frame_start: normal new frame; shadow[0]<=in_data, slot<=1.
  - slot!=0 & frame_start (early marker): sync_err pulse. The partial frame is discarded (out_data unchanged, no frame_valid). shadow[0]<=in_data, slot<=1, stay in RUN.
  - slot==0 & !frame_start (missing marker): sync_err pulse, beat dropped, slot stays 0, go to HUNT.
- Slot-7 completion and the following slot-0 beat on back-to-back cycles are legal: frame_valid for frame N coincides with the slot-0 capture of frame N+1.
- The shadow register is internal. out_data changes only on completion, so it is never torn.
- Reset mid-frame discards the shadow contents and returns to HUNT immediately.
- Slot write enable is a one-hot decode of slot gated by in_valid and the FSM. No X is propagated; for an out-of-range decode index, no enable is asserted.

Decomposition:
- Shared package tdm_pkg:
  - NCH=8, SELW=3.
  - State typedef {HUNT, RUN}.
  - Function for the channel bit offset.
- One natural sub-module: demux1to8_dec, a combinational 3-to-8 one-hot decoder with enable (the inverse of the 8:1 select). Instantiated once to generate the shadow write enables.

Test Plan:
- Reset, then 8 valid beats with frame_start on the first, data 0..7 (WIDTH=4) -> one cycle after the 8th beat: frame_valid=1 for exactly one cycle, out_data=32'h76543210, locked=1, slot=0.
- Same frame with in_valid low on alternate cycles -> identical out_data. frame_valid arrives one cycle after the slot-7 beat; slot holds during gaps.
- In HUNT, 3 beats without frame_start, then an aligned frame A..H -> first 3 beats dropped, no sync_err; out_data=32'hHGFEDCBA pattern (use 0xF..0x8 -> 32'h89ABCDEF).
- Mid-frame at slot=4, assert frame_start with data 9 -> sync_err pulse, no frame_valid, previous out_data kept, slot=1. The next 7 beats complete the frame with channel 0 = 9.
- After a complete frame, a valid beat with no frame_start -> sync_err pulse, locked=0, out_data unchanged.
- Assert rst while slot=5 -> out_data=0, slot=0, locked=0 asynchronously. A subsequent aligned frame decodes correctly.
